// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state types, 8N1 frame constants and divider helper
package uart_pkg;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  localparam int DATA_BITS = 8;
  localparam int OVS = 16;
  localparam int MID = 8;
  function automatic int calc_div(input int clk_hz, input int rate);
    return (clk_hz / rate < 1) ? 1 : clk_hz / rate;
  endfunction
endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: wrap-around divider pulsing tick_o once every DIV cycles
module uart_tick_gen #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick_o
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == CW'(DIV - 1);
  // count restarts on clr or after reaching DIV-1
  always_comb cnt_d = (clr || tick_o) ? '0 : cnt_q + CW'(1);
  // count register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl: byte-level 8N1 UART with strobe edge detect and one-byte rx holding register
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_we_n_i,
  input  logic       uart_re_n_i,
  input  logic [7:0] uart_tx_data_i,
  output logic       uart_tx_ready_o,
  output logic       uart_rx_ready_o,
  output logic [7:0] uart_rx_data_o,
  output logic       txd_o,
  input  logic       rxd_i
);
  localparam int TX_DIV = calc_div(CLK_FREQ, BAUD);
  localparam int RX_DIV = calc_div(CLK_FREQ, BAUD * OVS);
  if (OVERSAMPLE != OVS) begin : g_ovs_check
    $error("uart_ctrl: OVERSAMPLE must be 16");
  end
  logic prev_we_q, prev_re_q, wr_fire, rd_fire;
  tx_state_e tx_st_q, tx_st_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [2:0] tx_idx_q, tx_idx_d;
  logic tx_tick;
  rx_state_e rx_st_q, rx_st_d;
  logic [7:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic [2:0] rx_idx_q, rx_idx_d;
  logic [3:0] ocnt_q, ocnt_d;
  logic rx_err_q, rx_err_d, rx_rdy_q, rx_rdy_d, rx_s1_q, rx_s2_q, rx_tick, rx_load;
  assign wr_fire = ~uart_we_n_i & prev_we_q;
  assign rd_fire = ~uart_re_n_i & prev_re_q;
  uart_tick_gen #(.DIV(TX_DIV)) u_tx_tick (.clk(clk), .rst(rst), .clr(tx_st_q == TX_IDLE), .tick_o(tx_tick));
  uart_tick_gen #(.DIV(RX_DIV)) u_rx_tick (.clk(clk), .rst(rst), .clr(rx_st_q == RX_IDLE), .tick_o(rx_tick));
  // state, shift registers, strobe history and rxd synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_we_q <= 1'b1;
      prev_re_q <= 1'b1;
      tx_st_q   <= TX_IDLE;
      tx_sh_q   <= '0;
      tx_idx_q  <= '0;
      rx_st_q   <= RX_IDLE;
      rx_sh_q   <= '0;
      rx_idx_q  <= '0;
      ocnt_q    <= '0;
      rx_err_q  <= 1'b0;
      rx_rdy_q  <= 1'b0;
      rx_data_q <= '0;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
    end else begin
      prev_we_q <= uart_we_n_i;
      prev_re_q <= uart_re_n_i;
      tx_st_q   <= tx_st_d;
      tx_sh_q   <= tx_sh_d;
      tx_idx_q  <= tx_idx_d;
      rx_st_q   <= rx_st_d;
      rx_sh_q   <= rx_sh_d;
      rx_idx_q  <= rx_idx_d;
      ocnt_q    <= ocnt_d;
      rx_err_q  <= rx_err_d;
      rx_rdy_q  <= rx_rdy_d;
      rx_data_q <= rx_data_d;
      rx_s1_q   <= rxd_i;
      rx_s2_q   <= rx_s1_q;
    end
  end
  // tx: latch byte on a write strobe in idle, then start, 8 data bits LSB first, stop
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_sh_d  = tx_sh_q;
    tx_idx_d = tx_idx_q;
    case (tx_st_q)
      TX_IDLE: if (wr_fire) begin
        tx_sh_d  = uart_tx_data_i;
        tx_idx_d = '0;
        tx_st_d  = TX_START;
      end
      TX_START: if (tx_tick) tx_st_d = TX_DATA;
      TX_DATA: if (tx_tick) begin
        tx_sh_d  = tx_sh_q >> 1;
        tx_idx_d = tx_idx_q + 3'd1;
        if (tx_idx_q == 3'(DATA_BITS - 1)) tx_st_d = TX_STOP;
      end
      TX_STOP: if (tx_tick) tx_st_d = TX_IDLE;
    endcase
  end
  // rx: confirm start at mid-bit, sample data at bit centres, validate stop bit
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_sh_d  = rx_sh_q;
    rx_idx_d = rx_idx_q;
    ocnt_d   = ocnt_q;
    rx_err_d = rx_err_q;
    rx_load  = 1'b0;
    case (rx_st_q)
      RX_IDLE: begin
        ocnt_d = '0;
        if (!rx_s2_q) rx_st_d = RX_START;
      end
      RX_START: if (rx_tick) begin
        ocnt_d = ocnt_q + 4'd1;
        if (ocnt_q == 4'(MID - 1)) begin
          ocnt_d   = '0;
          rx_idx_d = '0;
          rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: if (rx_tick) begin
        ocnt_d = ocnt_q + 4'd1;
        if (ocnt_q == 4'(OVS - 1)) begin
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_idx_d = rx_idx_q + 3'd1;
          if (rx_idx_q == 3'(DATA_BITS - 1)) rx_st_d = RX_STOP;
        end
      end
      RX_STOP: if (rx_err_q) begin
        if (rx_s2_q) begin
          rx_err_d = 1'b0;
          rx_st_d  = RX_IDLE;
        end
      end else if (rx_tick) begin
        ocnt_d = ocnt_q + 4'd1;
        if (ocnt_q == 4'(OVS - 1)) begin
          rx_load  = rx_s2_q;
          rx_err_d = ~rx_s2_q;
          rx_st_d  = rx_s2_q ? RX_IDLE : RX_STOP;
        end
      end
    endcase
  end
  // holding register: a completed byte wins over a concurrent read
  always_comb begin
    rx_rdy_d  = rx_load | (rx_rdy_q & ~rd_fire);
    rx_data_d = rx_load ? rx_sh_q : rx_data_q;
  end
  assign uart_tx_ready_o = tx_st_q == TX_IDLE;
  assign txd_o           = (tx_st_q == TX_START) ? 1'b0 : (tx_st_q == TX_DATA) ? tx_sh_q[0] : 1'b1;
  assign uart_rx_ready_o = rx_rdy_q;
  assign uart_rx_data_o  = rx_data_q;
endmodule
